// File: rtl/ub_port_arbiter.sv
// Burst arbiter and sequencer for the unified buffer access port. The host has fixed
// priority, ctrl and dma alternate round-robin, and each granted burst issues one UB access per beat.
module ub_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  // Handshake: a requester holds req (with we/addr/count stable) until its done pulse.
  // gnt marks ownership; in every cycle where beat is high, the owner's wdata is consumed
  // (write) or one read is issued, and each read returns rvalid exactly RD_LAT cycles later.
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [ADDR_W-1:0] host_count,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_beat,
  output logic              host_rvalid,
  output logic              host_done,
  input  logic              ctrl_req,
  input  logic              ctrl_we,
  input  logic [ADDR_W-1:0] ctrl_addr,
  input  logic [ADDR_W-1:0] ctrl_count,
  input  logic [DATA_W-1:0] ctrl_wdata,
  output logic              ctrl_gnt,
  output logic              ctrl_beat,
  output logic              ctrl_rvalid,
  output logic              ctrl_done,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [ADDR_W-1:0] dma_count,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_beat,
  output logic              dma_rvalid,
  output logic              dma_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              ub_rd_en,
  output logic              ub_wr_en,
  output logic [ADDR_W-1:0] ub_addr,
  output logic [DATA_W-1:0] ub_wdata,
  input  logic [DATA_W-1:0] ub_rd_data,
  input  logic              ub_busy,
  output logic              arb_busy,
  output logic [1:0]        arb_owner,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_HOST = 2'd1;
  localparam logic [1:0] OWN_CTRL = 2'd2;
  localparam logic [1:0] OWN_DMA  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [1:0]        owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rem_q;
  logic              rr_dma;
  logic [2:0]        gnt_q;
  logic [2:0]        done_q;
  logic [RD_LAT-1:0] pipe_v;
  logic [1:0]        pipe_o [RD_LAT];

  logic [1:0]        win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [ADDR_W-1:0] win_count;
  logic              owner_req;
  logic              beat;
  logic              pend;

  // Bit 0 host, bit 1 ctrl, bit 2 dma.
  function automatic logic [2:0] onehot(input logic [1:0] o);
    case (o)
      OWN_HOST: onehot = 3'b001;
      OWN_CTRL: onehot = 3'b010;
      OWN_DMA:  onehot = 3'b100;
      default:  onehot = 3'b000;
    endcase
  endfunction

  // rr_dma set means dma won the last ctrl/dma contest, so ctrl wins the next tie.
  always_comb begin
    win = OWN_NONE;
    if (host_req)                 win = OWN_HOST;
    else if (ctrl_req && dma_req) win = rr_dma ? OWN_CTRL : OWN_DMA;
    else if (ctrl_req)            win = OWN_CTRL;
    else if (dma_req)             win = OWN_DMA;
  end

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_count = '0;
    case (win)
      OWN_HOST: begin win_we = host_we; win_addr = host_addr; win_count = host_count; end
      OWN_CTRL: begin win_we = ctrl_we; win_addr = ctrl_addr; win_count = ctrl_count; end
      OWN_DMA:  begin win_we = dma_we;  win_addr = dma_addr;  win_count = dma_count;  end
      default:  ;
    endcase
  end

  always_comb begin
    owner_req = 1'b0;
    ub_wdata  = '0;
    case (owner)
      OWN_HOST: begin owner_req = host_req; ub_wdata = host_wdata; end
      OWN_CTRL: begin owner_req = ctrl_req; ub_wdata = ctrl_wdata; end
      OWN_DMA:  begin owner_req = dma_req;  ub_wdata = dma_wdata;  end
      default:  ;
    endcase
  end

  // Reads still travelling toward the rvalid stage; the last stage is being delivered now.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) pend = pend | pipe_v[i];
  end

  assign beat = (state == S_BURST) && owner_req && !ub_busy && (rem_q != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win != OWN_NONE) state_nxt = S_BURST;
      S_BURST: begin
        if (!owner_req)                        state_nxt = (!we_q && pend) ? S_DRAIN : S_DONE;
        else if (rem_q == '0)                  state_nxt = S_DONE;
        else if (beat && rem_q == ADDR_W'(1))  state_nxt = we_q ? S_DONE : S_DRAIN;
      end
      S_DRAIN: if (!pend) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      owner  <= OWN_NONE;
      we_q   <= 1'b0;
      addr_q <= '0;
      rem_q  <= '0;
      rr_dma <= 1'b1;
      gnt_q  <= 3'b000;
      done_q <= 3'b000;
    end else begin
      state  <= state_nxt;
      done_q <= (state_nxt == S_DONE) ? onehot(owner) : 3'b000;
      case (state)
        S_IDLE: if (win != OWN_NONE) begin
          owner  <= win;
          we_q   <= win_we;
          addr_q <= win_addr;
          rem_q  <= win_count;
          gnt_q  <= onehot(win);
          if (win == OWN_CTRL)     rr_dma <= 1'b0;
          else if (win == OWN_DMA) rr_dma <= 1'b1;
        end
        S_BURST: if (beat) begin
          addr_q <= addr_q + ADDR_W'(1);
          rem_q  <= rem_q - ADDR_W'(1);
        end
        S_DONE: begin
          owner <= OWN_NONE;
          gnt_q <= 3'b000;
        end
        default: ;
      endcase
    end
  end

  // Read-return tracker: one stage per cycle of UB read latency, tagged with the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_o[i] <= OWN_NONE;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_o[i] <= pipe_o[i-1];
      end
      pipe_v[0] <= beat && !we_q;
      pipe_o[0] <= owner;
    end
  end

  assign ub_rd_en  = beat && !we_q;
  assign ub_wr_en  = beat && we_q;
  assign ub_addr   = (state == S_BURST) ? addr_q : '0;
  assign host_beat = beat && (owner == OWN_HOST);
  assign ctrl_beat = beat && (owner == OWN_CTRL);
  assign dma_beat  = beat && (owner == OWN_DMA);

  assign host_gnt  = gnt_q[0];
  assign ctrl_gnt  = gnt_q[1];
  assign dma_gnt   = gnt_q[2];
  assign host_done = done_q[0];
  assign ctrl_done = done_q[1];
  assign dma_done  = done_q[2];

  assign host_rvalid = pipe_v[RD_LAT-1] && (pipe_o[RD_LAT-1] == OWN_HOST);
  assign ctrl_rvalid = pipe_v[RD_LAT-1] && (pipe_o[RD_LAT-1] == OWN_CTRL);
  assign dma_rvalid  = pipe_v[RD_LAT-1] && (pipe_o[RD_LAT-1] == OWN_DMA);

  assign rd_data   = ub_rd_data;
  assign arb_busy  = (state != S_IDLE);
  assign arb_owner = owner;
  assign dbg_state = state;

endmodule

// File: doc/ub_port_arbiter.md
# ub_port_arbiter

Burst-level arbiter and sequencer for the unified buffer (UB) single access port. It shares the port among three requesters: the UART host test interface, the instruction controller, and the legacy DMA. For each granted burst it latches the requester's address, count and direction, then issues one UB access per beat with an incrementing address. It returns read data with a per-requester valid. It replaces the combinational priority mux in front of the UB and sits between those requesters and the datapath UB port.

## Interface
Parameters:
- ADDR_W, 9, UB address width
- DATA_W, 256, UB word width
- RD_LAT, 1, UB read latency in cycles (1..4)

Ports (R ∈ {host, ctrl, dma}, one set per requester):
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- R_req  in  1  burst request; hold high until R_done
- R_we  in  1  1 = write burst, 0 = read burst; sampled at grant
- R_addr  in  ADDR_W  burst start address; sampled at grant
- R_count  in  ADDR_W  beats in burst; sampled at grant
- R_wdata  in  DATA_W  write data for the current beat
- R_gnt  out  1  requester owns the port
- R_beat  out  1  current beat accepted (write data consumed / read issued)
- R_rvalid  out  1  rd_data valid for this requester
- R_done  out  1  one-cycle burst-complete pulse
- rd_data  out  DATA_W  shared read data, equal to ub_rd_data
- ub_rd_en, ub_wr_en  out  1  UB access strobes
- ub_addr  out  ADDR_W  UB address
- ub_wdata  out  DATA_W  owner's R_wdata
- ub_rd_data  in  DATA_W  UB read data
- ub_busy  in  1  UB stall; no beat is issued while high
- arb_busy  out  1  state ≠ IDLE
- arb_owner  out  2  0 none, 1 host, 2 ctrl, 3 dma

## Operation
- States: IDLE, BURST, DRAIN, DONE.
- IDLE: arbitrate among asserted requests.
  - host has fixed highest priority.
  - ctrl and dma share round-robin via a last-winner pointer; the pointer resets to "dma", so ctrl wins the first tie.
  - The winner's we/addr/count are latched and the remaining-beat counter is loaded with count; the FSM enters BURST.
- BURST: a beat fires when owner_req && !ub_busy && remaining > 0.
  - On a beat: R_beat = 1, ub_rd_en or ub_wr_en = 1, ub_addr = current address.
  - After each beat the address increments modulo 2^ADDR_W (511 → 0) and the counter decrements.
- Leaving BURST:
  - When remaining reaches 0, a read burst goes to DRAIN and a write burst goes to DONE.
  - Abort: if the owner drops R_req in BURST, no further beats are issued. The FSM goes to DRAIN (read with beats outstanding) or DONE, and R_done still pulses.
- DRAIN: wait until every issued read has returned its R_rvalid, then go to DONE.
- DONE: R_done = 1 for one cycle, R_gnt stays 1 during it, then the FSM returns to IDLE.
- count = 0: BURST issues no beats, so the FSM goes straight to DONE. The UB sees no access.
- R_rvalid: a per-beat shift register of depth RD_LAT tagged with the owner. R_rvalid = 1 exactly RD_LAT cycles after each read beat. Only the owner's R_rvalid is ever asserted.
- Decode outputs: ub_rd_en, ub_wr_en, R_beat, ub_addr and ub_wdata are combinational from state, counter and ub_busy. All other outputs are registered.
- Non-owner R_gnt, R_beat, R_rvalid and R_done are 0 at all times.

## Timing
- Reset (async assert, sync release): state IDLE, all gnt/beat/rvalid/done = 0, ub_rd_en = ub_wr_en = 0, ub_addr = 0, arb_busy = 0, arb_owner = 0, RR pointer = dma.
- Request → grant: R_req seen in IDLE at cycle T gives R_gnt = 1 and the first possible beat at T+1.
- Write burst of N beats with no stall:
  - beats at T+1..T+N
  - R_done at T+N+1
  - IDLE at T+N+2
  - next grant at T+N+3 at the earliest
- Read burst of N beats with no stall:
  - last R_rvalid at T+N+RD_LAT
  - R_done in the cycle after the last R_rvalid
- ub_busy high in a cycle: no beat that cycle; address, counter and data are held. Each stall cycle adds one cycle of latency.
- Simultaneous events:
  - Requests arriving while the FSM is not IDLE wait; arbitration happens only in IDLE.
  - A host request that arrives mid-burst does not preempt the current burst.
- Reset mid-burst: the burst is discarded with no R_done, and pending R_rvalid is dropped.

## Test plan
- Host write, addr 0x010, count 4, no stall:
  - ub_wr_en at T+1..T+4 with ub_addr 0x010..0x013, ub_wdata = host_wdata
  - host_done at T+5
- ctrl and dma both requesting single-beat reads, held for 4 bursts → grants alternate ctrl, dma, ctrl, dma. With host_req also high at the first IDLE → host is granted first.
- Read, addr 0x1FE, count 4, RD_LAT = 2:
  - ub_addr 0x1FE, 0x1FF, 0x000, 0x001
  - ctrl_rvalid at T+3..T+6, rd_data = ub_rd_data
  - ctrl_done at T+7
- Write count 3, ub_busy high at T+2 and T+3:
  - beats at T+1, T+4, T+5, address held at addr+1 during the stall
  - done at T+6
- Abort and zero-count:
  - dma read count 8 with dma_req dropped after beat 3 → exactly 3 rd_en, 3 dma_rvalid, dma_done pulses, then IDLE
  - count 0 → no UB strobe, done at T+2
- rst asserted mid 6-beat ctrl write after 2 beats:
  - all outputs 0 asynchronously, no ctrl_done
  - after release, a new ctrl request is granted after 1 cycle
